// File: rtl/lowx_mem_responder_pkg.sv
// Local types and the line merge helper for lowx_mem_responder.
package lowx_mem_responder_pkg;

    import tcore_param::*;

    localparam int unsigned BOFFSET   = $clog2(BLK_SIZE / 8);
    localparam int unsigned LFSR_W    = 16;
    localparam int unsigned STALL_W   = 3;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Overlay a byte/half/word/full-line store onto an existing line.
    function automatic logic [BLK_SIZE-1:0] merge_line(
        input logic [BLK_SIZE-1:0] old_line,
        input logic [BLK_SIZE-1:0] wdata,
        input logic [BOFFSET-1:0]  off,
        input logic                uncached,
        input logic [1:0]          rw_size
    );
        logic [BLK_SIZE-1:0] mask;
        logic [BLK_SIZE-1:0] lane;
        logic [BOFFSET-1:0]  base;
        logic [BOFFSET+2:0]  sh;
        mask = '0;
        lane = '0;
        base = off;
        case (rw_size)
            RW_BYTE: begin
                mask = BLK_SIZE'(8'hFF);
                lane = BLK_SIZE'(wdata[7:0]);
                base = off;
            end
            RW_HALF: begin
                mask = BLK_SIZE'(16'hFFFF);
                lane = BLK_SIZE'(wdata[15:0]);
                base = off & ~BOFFSET'(1);
            end
            RW_WORD: begin
                if (uncached) begin
                    mask = BLK_SIZE'(32'hFFFF_FFFF);
                    lane = BLK_SIZE'(wdata[31:0]);
                    base = off & ~BOFFSET'(3);
                end else begin
                    mask = '1;
                    lane = wdata;
                    base = '0;
                end
            end
            default: begin
                mask = '0;
                lane = '0;
            end
        endcase
        sh = {base, 3'b000};
        return (old_line & ~(mask << sh)) | (lane << sh);
    endfunction

endpackage

// File: rtl/tcore_param.sv
// Shared lowX bus definitions used by the caches and the memory responder.
package tcore_param;

    localparam int unsigned BLK_SIZE = 128;
    localparam int unsigned XLEN     = 32;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_BYTE = 2'b01;
    localparam logic [1:0] RW_HALF = 2'b10;
    localparam logic [1:0] RW_WORD = 2'b11;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic [XLEN-1:0]     addr;
        logic                uncached;
        logic                rw;
        logic [1:0]          rw_size;
        logic [BLK_SIZE-1:0] data;
    } lowx_req_t;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic [BLK_SIZE-1:0] data;
    } lowx_res_t;

endpackage

// File: rtl/lowx_mem_responder_lfsr.sv
// 16-bit Galois LFSR used for random response stalls; only built with
// LOWX_RESP_RANDOM_STALL_EN defined.
`ifdef LOWX_RESP_RANDOM_STALL_EN
module lowx_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Taps for x^16 + x^14 + x^13 + x^11 + 1.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule
`endif

// File: rtl/lowx_mem_responder.sv
// lowX memory-side responder: one request at a time, fixed-latency line storage.
// Define LOWX_RESP_RANDOM_STALL_EN to add 0-7 LFSR-driven stall cycles and stall_cnt_o.
module lowx_mem_responder
    import tcore_param::*;
    import lowx_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_LINES = 1024,
    parameter int unsigned LATENCY   = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  lowx_req_t lowX_req_i,
`ifdef LOWX_RESP_RANDOM_STALL_EN
    output logic [2:0] stall_cnt_o,
`endif
    output lowx_res_t lowX_res_o
);

    localparam int unsigned IDX_W = $clog2(MEM_LINES);
    localparam int unsigned CNT_W = $clog2(LATENCY + 8) + 1;

    logic [BLK_SIZE-1:0] mem [MEM_LINES];

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                rw_q, rw_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic [BLK_SIZE-1:0] data_q, data_d;

    logic                accept;
    logic [IDX_W-1:0]    idx_in;
    logic [BOFFSET-1:0]  off_in;
    logic [CNT_W-1:0]    lat_total;
    logic                unused_addr_hi;

    assign idx_in         = lowX_req_i.addr[BOFFSET +: IDX_W];
    assign off_in         = lowX_req_i.addr[BOFFSET-1:0];
    assign unused_addr_hi = ^lowX_req_i.addr[XLEN-1:BOFFSET+IDX_W];
    assign accept         = ready_q && lowX_req_i.valid;

`ifdef LOWX_RESP_RANDOM_STALL_EN
    logic [LFSR_W-1:0]  lfsr;
    logic [STALL_W-1:0] stall_q, stall_d;

    lowx_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (1'b1),
        .lfsr_o (lfsr)
    );

    assign lat_total   = CNT_W'(LATENCY) + CNT_W'(lfsr[STALL_W-1:0]);
    assign stall_cnt_o = stall_q;
`else
    assign lat_total = CNT_W'(LATENCY);
`endif

    // Next-state, counter and response computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        data_d  = data_q;
`ifdef LOWX_RESP_RANDOM_STALL_EN
        stall_d = stall_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    idx_d = idx_in;
                    rw_d  = lowX_req_i.rw;
`ifdef LOWX_RESP_RANDOM_STALL_EN
                    stall_d = lfsr[STALL_W-1:0];
`endif
                    if (lat_total == CNT_W'(1)) begin
                        state_d = ST_RESP;
                        data_d  = lowX_req_i.rw ? '0 : mem[idx_in];
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = lat_total - CNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    data_d  = rw_q ? '0 : mem[idx_q];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (lowX_req_i.ready) begin
                    state_d = ST_IDLE;
                    data_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        valid_d = (state_d == ST_RESP);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rw_q    <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            data_q  <= '0;
`ifdef LOWX_RESP_RANDOM_STALL_EN
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            data_q  <= data_d;
`ifdef LOWX_RESP_RANDOM_STALL_EN
            stall_q <= stall_d;
`endif
        end
    end

    // Stores commit in the acceptance cycle; storage is not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && accept && lowX_req_i.rw) begin
            mem[idx_in] <= merge_line(mem[idx_in], lowX_req_i.data, off_in,
                                      lowX_req_i.uncached, lowX_req_i.rw_size);
        end
    end

    assign lowX_res_o = '{valid: valid_q, ready: ready_q, data: data_q};

endmodule

// File: doc/lowx_mem_responder.md
Name: lowx_mem_responder

Overview:
- Memory-side responder for the lowX line-fill/writeback protocol issued by the i-cache and d-cache.
- Accepts one request at a time: line read, uncached read, full-line writeback, or partial uncached store.
- Services it from an internal line-wide storage array after a fixed latency, then holds the response until the requester takes it.
- Serves as the backing memory for cache-level simulation and as the reference model for a future real memory controller.

Parameters:
- BLK_SIZE, tcore_param::BLK_SIZE, line width in bits (power of two, >=32).
- XLEN, tcore_param::XLEN, address width.
- MEM_LINES, 1024, number of lines stored (power of two).
- LATENCY, 4, cycles from request acceptance to first res.valid (>=1).
- lowX_req_t, logic, request struct type: valid, ready, addr[XLEN], uncached, rw, rw_size[2], data[BLK_SIZE].
- lowX_res_t, logic, response struct type: valid, ready, data[BLK_SIZE] (alias blk).

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- lowX_req_i  in  lowX_req_t  request from cache. valid = request present; ready = requester can consume a response.
- lowX_res_o  out  lowX_res_t  response. ready = request accepted this cycle; valid = response data/ack present; data = line.

Behaviour:
- Reset values: state IDLE; res.valid=0; res.ready=1 (combinational in IDLE); res.data=0; counter=0. Reset does not clear storage.
- Line index is addr[BOFFSET+$clog2(MEM_LINES)-1:BOFFSET], with BOFFSET=$clog2(BLK_SIZE/8). Upper address bits are ignored, so addresses wrap modulo MEM_LINES.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: res.ready=1. Acceptance occurs when req.valid && res.ready; capture addr, rw, rw_size, data, uncached.
  - On acceptance with LATENCY==1, go directly to RESP. Otherwise go to WAIT with counter=LATENCY-1.
  - WAIT: res.ready=0. Decrement the counter; when it reaches 1, go to RESP next cycle.
- Latency: acceptance at cycle T means res.valid is first high at T+LATENCY.
- RESP: res.valid=1 and res.ready=0.
  - Read: data = stored line (uncached reads return the full line).
  - Write: data = 0.
  - res.valid and data are held stable while req.ready=0 (requester flushing).
  - When req.ready=1 the handshake completes that cycle; next state is IDLE.
- Back-to-back requests: a new request is accepted no earlier than the cycle after the RESP handshake.
- Write commit happens in the acceptance cycle, so a following read of the same line returns the new data.
  - rw_size=11: full-line write when uncached=0 (writeback). When uncached=1, write only the 32-bit word at addr[BOFFSET-1:2].
  - rw_size=10: halfword at addr[BOFFSET-1:1]; write data is data[15:0].
  - rw_size=01: byte at addr[BOFFSET-1:0]; write data is data[7:0].
  - rw_size=00: no storage change; still respond.
- Read data is sampled at transition into RESP, so a same-line write cannot race it.
- Reset mid-operation: the next cycle is IDLE with res.valid=0. A pending read is dropped. A write already committed at acceptance persists.
- req.valid deasserting during WAIT/RESP is ignored; the captured request completes.

Optional Feature:
- Macro LOWX_RESP_RANDOM_STALL_EN.
- When defined: a 16-bit Galois LFSR (seed 16'hACE1 at reset, advancing every cycle) adds an extra 0-7 stall cycles in WAIT, taken from lfsr[2:0] sampled at acceptance.
  - Latency becomes LATENCY + lfsr[2:0].
  - Exposes output stall_cnt_o[2:0], the extra stall for the current request.
- When undefined: latency is exactly LATENCY, with no LFSR and no extra port.

Decomposition:
- tcore_param holds:
  - the shared lowx_req_t/lowx_res_t struct definitions used by caches and this block;
  - rw_size encoding constants RW_BYTE=2'b01, RW_HALF=2'b10, RW_WORD=2'b11, RW_NONE=2'b00.
- One sub-module, lowx_lfsr (16-bit, enable, seed parameter), instantiated only under LOWX_RESP_RANDOM_STALL_EN.
- Storage is a local array in the block, not sp_bram, because partial writes need byte-granular read-modify-write.

Test Plan (BLK_SIZE=128, LATENCY=4):
- Writeback: rw=1, rw_size=11, uncached=0, addr=0x40, data=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; then read addr=0x40 -> res.valid exactly 4 cycles after acceptance, data equals the written pattern.
- Byte store: uncached=1, rw_size=01, addr=0x43, data=0xAB -> read of 0x40 shows bits[31:24]=0xAB, other bytes unchanged.
- Backpressure: read accepted, req.ready=0 for 3 cycles once RESP is reached -> res.valid held high 4 cycles total, data constant, res.ready=0 throughout.
- Reset at the 2nd WAIT cycle of a read -> next cycle res.valid=0, res.ready=1; a new request is accepted immediately with a fresh 4-cycle latency.
- Wrap: write line at 0x0000_0010, read 0x0000_4010 (MEM_LINES=1024) -> same data returned.
- Back-to-back: req.valid held high across two reads -> second acceptance occurs exactly 1 cycle after the first RESP handshake; no request is lost or duplicated.
